// File: rtl/regbank_dumper_pkg.sv
// -----------------------------------------------------------------------------
// regbank_dumper_pkg
//   Shared core constants for the 32x32 register bank and its readback dumper.
//   Holds the bank geometry (address width, word width, register count) and
//   the dumper FSM state encoding, so the bank, the dumper and any checker
//   agree on the same numbers.
//
//   Contents:
//     REG_ADDR_W  register address width (5 -> 32 registers)
//     WORD_W      register data width
//     NUM_REGS    number of registers in the bank
//     STATE_W     width of the dumper state vector
//     ST_IDLE / ST_READ / ST_SEND  dumper state encoding
//     next_reg()  wrapping "address + 1" used to step through the bank
// -----------------------------------------------------------------------------
package regbank_dumper_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // Dumper FSM encoding. Kept as plain sized constants so the encoding is
    // visible on the debug state output without any enum casting.
    localparam int             STATE_W = 2;
    localparam logic [1:0]     ST_IDLE = 2'd0;
    localparam logic [1:0]     ST_READ = 2'd1;
    localparam logic [1:0]     ST_SEND = 2'd2;

    // Register addresses wrap modulo NUM_REGS: 31 + 1 -> 0.
    function automatic logic [REG_ADDR_W-1:0] next_reg(
        input logic [REG_ADDR_W-1:0] addr
    );
        return addr + REG_ADDR_W'(1);
    endfunction

endpackage : regbank_dumper_pkg

// File: rtl/regbank_addr_ctr.sv
// -----------------------------------------------------------------------------
// regbank_addr_ctr
//   Wrapping register-address counter for the dumper. It owns the bank read
//   address and the latched last index of the current dump range.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-high reset (addr and last cleared)
//     load       in   latch first_addr into addr and last_addr into the
//                     range-end register (start of a dump)
//     inc        in   step addr by one, wrapping 31 -> 0
//     first_addr in   first register index of the range
//     last_addr  in   last register index of the range, inclusive
//     addr       out  current register address (drives the bank read port)
//     is_last    out  addr equals the latched last index
//
//   load has priority over inc; the dumper never asserts both together.
// -----------------------------------------------------------------------------
module regbank_addr_ctr
    import regbank_dumper_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              is_last
);

    logic [ADDR_W-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= '0;
            last_q <= '0;
        end else if (load) begin
            addr   <= first_addr;
            last_q <= last_addr;
        end else if (inc) begin
            // Natural overflow of the ADDR_W-bit add gives the mod-32 wrap.
            addr <= addr + ADDR_W'(1);
        end
    end

    // The range is inclusive and walked upward with wrap, so the dump ends
    // exactly when the live address reaches the latched end. This also makes
    // first == last a one-word dump and first == last+1 a full 32-word sweep.
    assign is_last = (addr == last_q);

endmodule : regbank_addr_ctr

// File: rtl/regbank_dumper.sv
// -----------------------------------------------------------------------------
// regbank_dumper
//   Sequential readback client for the 32x32 register bank. On start it walks
//   the wrapping range firstReg..lastReg through one bank read port and
//   streams every (address, data) pair to a downstream sink.
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous active-high reset
//     start     in   begin a dump; only looked at in IDLE
//     abort     in   synchronous cancel, back to IDLE at the next edge
//     firstReg  in   first register index, captured with start
//     lastReg   in   last register index (inclusive), captured with start
//     readAdd   out  address to the bank read port
//     readData  in   combinational bank read data for readAdd
//     outValid  out  outAddr/outData hold a word
//     outReady  in   sink accepts the word
//     outAddr   out  register index of the word on the output
//     outData   out  register contents of the word on the output
//     busy      out  high from start acceptance until the final transfer
//     done      out  one-cycle pulse after the final transfer (not on abort)
//     fsm_state out  current FSM state (ST_IDLE / ST_READ / ST_SEND), debug
//
//   Output handshake: a word moves on any rising edge where outValid and
//   outReady are both high. Once outValid rises, outValid/outAddr/outData
//   hold steady until that transfer edge; only abort or rst withdraw them.
//   outValid is a register, so outReady has no combinational path to it.
//
//   Cycle shape per word: READ (bank address settles for a full cycle and is
//   captured at its closing edge), then SEND (held until accepted). With
//   outReady tied high this gives one word every two cycles.
// -----------------------------------------------------------------------------
module regbank_dumper #(
    parameter int REG_ADDR_W = regbank_dumper_pkg::REG_ADDR_W,
    parameter int WORD_W     = regbank_dumper_pkg::WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [REG_ADDR_W-1:0] firstReg,
    input  logic [REG_ADDR_W-1:0] lastReg,
    output logic [REG_ADDR_W-1:0] readAdd,
    input  logic [WORD_W-1:0]     readData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [REG_ADDR_W-1:0] outAddr,
    output logic [WORD_W-1:0]     outData,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    import regbank_dumper_pkg::*;

    logic [STATE_W-1:0] state;
    logic               xfer;
    logic               ctr_load;
    logic               ctr_inc;
    logic               ctr_is_last;

    // outValid is only ever high in SEND, so this is the SEND transfer edge.
    assign xfer = outValid && outReady;

    // Abort blocks the range capture and the address step, so a cancelled
    // request leaves no trace in the counter.
    assign ctr_load = (state == ST_IDLE) && start && !abort;
    assign ctr_inc  = (state == ST_SEND) && xfer && !ctr_is_last && !abort;

    regbank_addr_ctr #(
        .ADDR_W (REG_ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .inc        (ctr_inc),
        .first_addr (firstReg),
        .last_addr  (lastReg),
        .addr       (readAdd),
        .is_last    (ctr_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            outValid <= 1'b0;
            outAddr  <= '0;
            outData  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // done is a single-cycle pulse; it is only set on the last
            // transfer edge below.
            done <= 1'b0;

            if (abort) begin
                // A handshake in this same cycle still reaches the sink, but
                // the dump ends here with no done pulse.
                state    <= ST_IDLE;
                outValid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                        end
                    end

                    ST_READ: begin
                        outData  <= readData;
                        outAddr  <= readAdd;
                        outValid <= 1'b1;
                        state    <= ST_SEND;
                    end

                    ST_SEND: begin
                        if (xfer) begin
                            outValid <= 1'b0;
                            if (ctr_is_last) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a quiet IDLE.
                        state    <= ST_IDLE;
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fsm_state = state;

endmodule : regbank_dumper

// File: tb/tb_regbank_dumper.sv
// -----------------------------------------------------------------------------
// tb_regbank_dumper
//   Bench for regbank_dumper. A behavioural 32x32 bank (reg0 hardwired to 0)
//   feeds readData; the expected stream for each dump is built from the range
//   rule: N = ((last - first) mod 32) + 1 words at addresses first+i mod 32.
// -----------------------------------------------------------------------------
module tb_regbank_dumper;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  firstReg;
    logic [4:0]  lastReg;
    logic [4:0]  readAdd;
    logic [31:0] readData;
    logic        outValid;
    logic        outReady;
    logic [4:0]  outAddr;
    logic [31:0] outData;
    logic        busy;
    logic        done;
    logic [1:0]  fsm_state;

    logic [31:0] bank [32];
    logic [36:0] exp_q [$];

    int tests_run;
    int tests_failed;

    regbank_dumper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .firstReg  (firstReg),
        .lastReg   (lastReg),
        .readAdd   (readAdd),
        .readData  (readData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outAddr   (outAddr),
        .outData   (outData),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // Bank read port: combinational, register 0 always reads zero.
    assign readData = (readAdd == 5'd0) ? 32'd0 : bank[readAdd];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : bank[a];
    endfunction

    task automatic fill_bank(input bit random_fill);
        for (int i = 0; i < 32; i++)
            bank[i] = random_fill ? $urandom() : 32'(100 + i);
        bank[0] = 32'd0;
    endtask

    // ---------------- drivers ----------------
    // Runs one complete dump. Each word may be held off for up to max_stall
    // cycles of outReady low. With poke set, a second start with a different
    // range is pulsed while the first word is waiting; it must be ignored.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l,
                           input int max_stall, input bit poke);
        int n;
        int s;
        logic [4:0]  a;
        logic [4:0]  held_addr;
        logic [31:0] held_data;
        logic [36:0] e;

        n = ((int'(l) - int'(f)) & 31) + 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = f + 5'(i);
            exp_q.push_back({a, model_read(a)});
        end

        @(negedge clk);
        start    = 1'b1;
        firstReg = f;
        lastReg  = l;
        outReady = 1'b0;
        @(negedge clk);                       // just after acceptance edge k
        start    = 1'b0;
        firstReg = 5'($urandom_range(0, 31)); // range inputs now don't care
        lastReg  = 5'($urandom_range(0, 31));
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_readadd", 64'(readAdd), 64'(f));
        check("accept_valid", 64'(outValid), 64'd0);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);                   // one cycle after READ began
            check("word_valid", 64'(outValid), 64'd1);
            held_addr = outAddr;
            held_data = outData;
            s = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
            if (poke && i == 0) begin
                start    = 1'b1;
                firstReg = f + 5'd9;
                lastReg  = f + 5'd20;
                if (s == 0) s = 1;
            end
            outReady = (s == 0);
            for (int k = 0; k < s; k++) begin
                @(negedge clk);
                start = 1'b0;
                check("hold_valid", 64'(outValid), 64'd1);
                check("hold_addr", 64'(outAddr), 64'(held_addr));
                check("hold_data", 64'(outData), 64'(held_data));
                check("hold_busy_done", 64'({busy, done}), 64'b10);
                outReady = (k == s - 1);
            end
            e = exp_q.pop_front();
            check("word_addr", 64'(outAddr), 64'(e[36:32]));
            check("word_data", 64'(outData), 64'(e[31:0]));
            @(negedge clk);                   // just after the transfer edge
            outReady = (max_stall == 0);
            if (i < n - 1)
                check("between_words", 64'({outValid, busy, done}), 64'b010);
            else
                check("end_done", 64'({outValid, busy, done}), 64'b001);
        end
        outReady = 1'b0;
        @(negedge clk);
        check("done_pulse_drop", 64'({done, busy}), 64'b00);
    endtask

    // Two-or-more-word dump cancelled while the second word is offered.
    task automatic do_abort(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        start = 1'b1; firstReg = f; lastReg = l; outReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_w0_addr", 64'(outAddr), 64'(f));
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        @(negedge clk);
        check("abort_w1_valid", 64'(outValid), 64'd1);
        check("abort_w1_addr", 64'(outAddr), 64'(f + 5'd1));
        check("abort_w1_data", 64'(outData), 64'(model_read(f + 5'd1)));
        abort    = 1'b1;
        outReady = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort    = 1'b0;
        outReady = 1'b0;
        check("abort_next_edge", 64'({outValid, busy, done}), 64'b000);
        @(negedge clk);
        check("abort_no_done", 64'({outValid, busy, done}), 64'b000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        firstReg = '0;
        lastReg  = '0;
        outReady = 1'b0;
        fill_bank(1'b0);

        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({readAdd, outValid, outAddr, busy, done}), 64'd0);
        check("reset_data", 64'(outData), 64'd0);
        rst = 1'b0;

        // Single word, full sweep in order, wrap cases.
        bank[8] = 32'd18;
        do_dump(5'd8, 5'd8, 0, 1'b0);
        fill_bank(1'b0);
        do_dump(5'd0, 5'd31, 0, 1'b0);
        do_dump(5'd30, 5'd1, 0, 1'b0);
        do_dump(5'd5, 5'd4, 0, 1'b0);

        // Backpressure and an ignored start during SEND.
        do_dump(5'd2, 5'd4, 3, 1'b0);
        do_dump(5'd2, 5'd4, 3, 1'b1);

        // Abort during the second word, then a clean dump afterwards.
        do_abort(5'd10, 5'd20);
        do_dump(5'd12, 5'd14, 1, 1'b0);

        // Asynchronous reset while in READ, then a fresh dump.
        @(negedge clk);
        start = 1'b1; firstReg = 5'd0; lastReg = 5'd31; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                       // word 0 offered, accepted next edge
        @(negedge clk);                       // now in READ for word 1
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({readAdd, outValid, outAddr, busy, done}), 64'd0);
        check("rst_mid_data", 64'(outData), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b0;
        do_dump(5'd20, 5'd23, 0, 1'b0);

        // Randomized ranges, contents and backpressure.
        for (int t = 0; t < 8; t++) begin
            fill_bank(1'b1);
            do_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_regbank_dumper

// File: doc/regbank_dumper.md
# regbank_dumper

Sequential reader for the 32x32 register bank: on a start request it walks a contiguous (wrapping) range of register addresses through one bank read port and streams each (address, data) pair out over a valid/ready handshake. It sits beside the register bank as its debug and readback client, the consumer end of the write path. It drives one read-address port, typically readAddA, while the core is halted. Typical downstream sinks are a UART/LED display, a scan chain or a testbench scoreboard.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width (32 registers)
- WORD_W, 32, register data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE at the next edge
- firstReg  in  5  first register index; sampled with start
- lastReg  in  5  last register index, inclusive; sampled with start
- readAdd  out  5  address to the bank read port
- readData  in  32  combinational read data from the bank for readAdd
- outValid  out  1  outAddr/outData hold a word
- outReady  in  1  sink accepts the word
- outAddr  out  5  register index of the current word
- outData  out  32  register contents
- busy  out  1  high from start acceptance until the final transfer
- done  out  1  one-cycle pulse after the final transfer; not asserted on abort

## Operation
- States:
  - IDLE: start=1 latches firstReg and lastReg, sets readAdd=firstReg, and goes to READ.
  - READ: readAdd is stable for one full cycle. At the edge, outData<=readData, outAddr<=readAdd, outValid<=1, and the state goes to SEND.
  - SEND: outputs are held until outValid&outReady.
    - On the transfer edge, if the word just sent is lastReg: go to IDLE, outValid<=0, done<=1.
    - Otherwise: readAdd<=readAdd+1 (mod 32), outValid<=0, and go to READ.
- Word count is ((lastReg-firstReg) mod 32)+1.
  - firstReg==lastReg emits exactly one word.
  - firstReg>lastReg wraps through 31 to 0, e.g. 30..1 emits 30,31,0,1.
  - firstReg=lastReg+1 (mod 32) emits all 32 registers.
- start in READ or SEND is ignored. Range inputs are ignored except when start is sampled in IDLE.
- abort wins over every other event in the same cycle:
  - next state IDLE, outValid<=0, busy<=0, no done pulse.
  - A handshake in the same cycle as abort does count as a transfer at the sink, but it is not followed by done.
- Register 0 is read like any other register; it reads 0 from the bank.
- The dumper never writes the bank. The owner guarantees RegWrite=0 while busy. Data written during a dump is captured only if the write completes before the corresponding READ cycle.

## Timing
- Reset values: readAdd=0, outValid=0, outAddr=0, outData=0, busy=0, done=0, state IDLE.
  - Reset mid-dump applies these immediately (asynchronous), and the dump is lost.
- start is high at edge k:
  - busy=1 and readAdd=firstReg from k.
  - outValid=1 with the first word from k+1.
- Throughput: one word per 2 cycles when outReady is held high. An N-word dump takes 2N cycles from start to done.
- Once raised, outValid stays high and outAddr/outData stay constant until the transfer edge; valid is never withdrawn except by abort or rst.
- done is high for exactly the cycle after the final transfer edge; busy falls on that same edge.
- A start in the cycle where done is high is accepted, giving back-to-back dumps.
- All outputs are registered; no combinational path from outReady to outValid.

## Structure
- The shared core package holds REG_ADDR_W, WORD_W, NUM_REGS=32 and the dumper state encoding (IDLE, READ, SEND). The register bank uses the same width constants.
- One natural sub-module: regbank_addr_ctr, a 5-bit wrapping address counter with load(firstReg), increment, and an isLast compare against the latched lastReg.
- Everything else (FSM, output register, done pulse) stays flat in regbank_dumper.

## Test plan
- Preload reg8=18 via RegWrite=1, writeAdd=8. Dump 8..8 with outReady=1: one word (8,18), outValid seen at k+1, done at k+2, busy low at k+2.
- Preload regs 0..31 with value 100+i. Dump 0..31 with outReady=1: 32 words in order, reg0 reads 0 (bank hardwired), others 100+i, done at cycle 64 after start.
- Wrap case: dump 30..1 yields addresses 30,31,0,1 and then done; firstReg=5, lastReg=4 yields all 32 words starting at 5.
- Backpressure: dump 2..4 with outReady low for 3 cycles on each word. outAddr/outData stay stable while outValid=1, there are no duplicates or drops, and done follows the word for reg4.
- Mid-dump events:
  - start pulsed during SEND: ignored, range unchanged.
  - abort during the second word: outValid=0 and busy=0 next edge, no done pulse.
  - rst asserted mid-READ: all outputs 0 immediately; a fresh start afterwards dumps correctly.
